// File: rtl/mesi_cache_ctrl_pkg.sv
// Shared types for the MESI cache controller: line layout, coherence states,
// bus commands, address field positions and the CPU-side FSM states.
package cacheLinePackage;

   localparam int NUM_LINES = 4;
   localparam int TAG_LSB   = 6;
   localparam int IDX_LSB   = 4;
   localparam int WORD_LSB  = 2;
   localparam int TAG_W     = 32 - TAG_LSB;

   typedef enum logic [1:0] {INVALID, SHARED, EXCLUSIVE, MODIFIED} CacheState;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      CacheState        state;
      logic [TAG_W-1:0] tag;
      logic [127:0]     data;
   } cacheLine;

   typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR, BUS_FLUSH} BusCmd;

   typedef enum logic [2:0] {
      IDLE, WB_ARB, WB_WAIT, FILL_ARB, FILL_WAIT, UPG_ARB, UPG_WAIT
   } CtrlState;

   // valid/dirty are derived from state so every state change keeps them in step
   function automatic cacheLine set_state(cacheLine line, CacheState st);
      line.state = st;
      line.valid = (st != INVALID);
      line.dirty = (st == MODIFIED);
      return line;
   endfunction

   function automatic logic [127:0] merge_word(logic [127:0] blk, logic [1:0] word,
                                               logic [31:0] value);
      blk[word*32 +: 32] = value;
      return blk;
   endfunction

endpackage

// File: rtl/mesi_cache_ctrl_snoop.sv
// Snoop reaction table: next coherence state and whether dirty data must be
// flushed, for a line already known to match the snooped address.
module mesi_snoop_unit
   import cacheLinePackage::*;
(
   input  CacheState cur_state,
   input  BusCmd     cmd,
   output CacheState next_state,
   output logic      flush
);

   always_comb begin
      next_state = cur_state;
      flush      = 1'b0;
      case (cmd)
         BUS_RD: begin
            flush = (cur_state == MODIFIED);
            if (cur_state != INVALID) next_state = SHARED;
         end
         BUS_RDX: begin
            flush      = (cur_state == MODIFIED);
            next_state = INVALID;
         end
         BUS_UPGR: begin
            if (cur_state == SHARED) next_state = INVALID;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Per-core MESI controller over a 4-line direct-mapped cache: serves the CPU
// port, drives the snooping bus on misses/upgrades/evictions, answers snoops.
module mesi_cache_ctrl
   import cacheLinePackage::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic         cpu_we,
   input  logic [31:0]  cpu_addr,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_ack,
   output logic         bus_req,
   input  logic         bus_gnt,
   output logic [1:0]   bus_cmd,
   output logic [31:0]  bus_addr,
   output logic [127:0] bus_wdata,
   input  logic [127:0] bus_rdata,
   input  logic         bus_done,
   input  logic         bus_shared,
   input  logic         snoop_valid,
   input  logic [1:0]   snoop_cmd,
   input  logic [31:0]  snoop_addr,
   output logic         snoop_hit,
   output logic         snoop_flush,
   output logic [127:0] snoop_data
);

   cacheLine         lines [NUM_LINES];
   CtrlState         st;

   logic [1:0]       cidx, sidx, cword;
   logic [TAG_W-1:0] ctag, stag;
   logic [31:0]      blk_addr;
   cacheLine         cline, sline, wr_line, fill_line;
   logic             chit, smatch, s_on_cpu_line, sflush;
   CacheState        snext;
   BusCmd            fill_cmd;
   logic             unused_bits;

   assign cidx     = cpu_addr[IDX_LSB +: 2];
   assign cword    = cpu_addr[WORD_LSB +: 2];
   assign ctag     = cpu_addr[31:TAG_LSB];
   assign sidx     = snoop_addr[IDX_LSB +: 2];
   assign stag     = snoop_addr[31:TAG_LSB];
   assign blk_addr = {cpu_addr[31:IDX_LSB], 4'b0000};
   assign fill_cmd = cpu_we ? BUS_RDX : BUS_RD;
   assign cline    = lines[cidx];
   assign sline    = lines[sidx];
   assign chit     = cline.valid && (cline.tag == ctag);
   assign smatch   = snoop_valid && sline.valid && (sline.tag == stag);
   assign s_on_cpu_line = smatch && (sidx == cidx);
   assign wr_line  = set_state(cacheLine'{valid: cline.valid, dirty: cline.dirty,
                                          state: cline.state, tag: cline.tag,
                                          data: merge_word(cline.data, cword, cpu_wdata)},
                               MODIFIED);
   assign unused_bits = ^{cpu_addr[1:0], snoop_addr[3:0]};

   mesi_snoop_unit u_snoop (
      .cur_state  (sline.state),
      .cmd        (BusCmd'(snoop_cmd)),
      .next_state (snext),
      .flush      (sflush)
   );

   always_comb begin
      fill_line     = '0;
      fill_line.tag = ctag;
      if (cpu_we) begin
         fill_line.data = merge_word(bus_rdata, cword, cpu_wdata);
         fill_line      = set_state(fill_line, MODIFIED);
      end else begin
         fill_line.data = bus_rdata;
         fill_line      = set_state(fill_line, bus_shared ? SHARED : EXCLUSIVE);
      end
   end

   // Snoop update is written first so a CPU-side line write on the same edge wins
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LINES; i++) lines[i] <= '0;
         st          <= IDLE;
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         bus_req     <= 1'b0;
         bus_cmd     <= '0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         snoop_hit   <= 1'b0;
         snoop_flush <= 1'b0;
         snoop_data  <= '0;
      end else begin
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         snoop_hit   <= smatch;
         snoop_flush <= smatch && sflush;
         snoop_data  <= (smatch && sflush) ? sline.data : '0;
         if (smatch) lines[sidx] <= set_state(sline, snext);

         case (st)
            IDLE: begin
               // cpu_ack high means the core is still retiring the last request
               if (cpu_req && !cpu_ack && !s_on_cpu_line) begin
                  if (chit && (!cpu_we || cline.state != SHARED)) begin
                     cpu_ack <= 1'b1;
                     if (cpu_we) lines[cidx] <= wr_line;
                     else        cpu_rdata   <= cline.data[cword*32 +: 32];
                  end else if (chit) begin
                     st       <= UPG_ARB;
                     bus_req  <= 1'b1;
                     bus_cmd  <= BUS_UPGR;
                     bus_addr <= blk_addr;
                  end else if (cline.state == MODIFIED) begin
                     st        <= WB_ARB;
                     bus_req   <= 1'b1;
                     bus_cmd   <= BUS_FLUSH;
                     bus_addr  <= {cline.tag, cidx, 4'b0000};
                     bus_wdata <= cline.data;
                  end else begin
                     st       <= FILL_ARB;
                     bus_req  <= 1'b1;
                     bus_cmd  <= fill_cmd;
                     bus_addr <= blk_addr;
                  end
               end
            end
            WB_ARB, WB_WAIT: begin
               if (bus_done || (st == WB_ARB && !bus_gnt && s_on_cpu_line && snext != MODIFIED)) begin
                  // a snoop flush already handed the dirty victim to the bus
                  if (bus_done) lines[cidx] <= set_state(cline, INVALID);
                  st        <= FILL_ARB;
                  bus_cmd   <= fill_cmd;
                  bus_addr  <= blk_addr;
                  bus_wdata <= '0;
               end else if (bus_gnt) begin
                  st <= WB_WAIT;
               end
            end
            FILL_ARB, FILL_WAIT: begin
               if (bus_done) begin
                  lines[cidx] <= fill_line;
                  cpu_ack     <= 1'b1;
                  cpu_rdata   <= cpu_we ? 32'h0 : bus_rdata[cword*32 +: 32];
                  st          <= IDLE;
                  bus_req     <= 1'b0;
                  bus_cmd     <= '0;
                  bus_addr    <= '0;
               end else if (bus_gnt) begin
                  st <= FILL_WAIT;
               end
            end
            UPG_ARB, UPG_WAIT: begin
               if (bus_done) begin
                  lines[cidx] <= wr_line;
                  cpu_ack     <= 1'b1;
                  st          <= IDLE;
                  bus_req     <= 1'b0;
                  bus_cmd     <= '0;
                  bus_addr    <= '0;
               end else if (st == UPG_ARB && !bus_gnt && s_on_cpu_line && snext == INVALID) begin
                  st      <= FILL_ARB;
                  bus_cmd <= BUS_RDX;
               end else if (bus_gnt) begin
                  st <= UPG_WAIT;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed self-checking bench for mesi_cache_ctrl: misses, hits, upgrades,
// snoop interactions, dirty eviction and mid-transaction reset.
module tb_mesi_cache_ctrl;
   import cacheLinePackage::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_req, cpu_we;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic         cpu_ack;
   logic         bus_req, bus_gnt;
   logic [1:0]   bus_cmd;
   logic [31:0]  bus_addr;
   logic [127:0] bus_wdata, bus_rdata;
   logic         bus_done, bus_shared;
   logic         snoop_valid;
   logic [1:0]   snoop_cmd;
   logic [31:0]  snoop_addr;
   logic         snoop_hit, snoop_flush;
   logic [127:0] snoop_data;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] FILL_A = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
   localparam logic [127:0] FILL_B = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
   localparam logic [127:0] FILL_C = {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};
   localparam logic [127:0] FILL_D = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};

   mesi_cache_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .bus_cmd     (bus_cmd),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .bus_done    (bus_done),
      .bus_shared  (bus_shared),
      .snoop_valid (snoop_valid),
      .snoop_cmd   (snoop_cmd),
      .snoop_addr  (snoop_addr),
      .snoop_hit   (snoop_hit),
      .snoop_flush (snoop_flush),
      .snoop_data  (snoop_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      cpu_req   = req;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   task automatic snoop(input logic [1:0] cmd, input logic [31:0] addr);
      snoop_valid = 1'b1;
      snoop_cmd   = cmd;
      snoop_addr  = addr;
   endtask

   // Acts as arbiter and memory for one transaction: grant, then done with fill data
   task automatic serveBus(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [127:0] rdata, input logic shared,
                           input logic [127:0] wdata);
      int n = 0;
      while (!bus_req && n < 20) begin
         tick;
         n++;
      end
      checkOutput({tag, "_req"}, bus_req, 1);
      checkOutput({tag, "_cmd"}, bus_cmd, cmd);
      checkOutput({tag, "_addr"}, bus_addr, addr);
      if (cmd == BUS_FLUSH) checkOutput({tag, "_wdata"}, bus_wdata, wdata);
      bus_gnt = 1'b1;
      tick;
      bus_gnt = 1'b0;
      checkOutput({tag, "_cmd_held"}, bus_cmd, cmd);
      checkOutput({tag, "_addr_held"}, bus_addr, addr);
      bus_done   = 1'b1;
      bus_rdata  = rdata;
      bus_shared = shared;
      tick;
      bus_done   = 1'b0;
      bus_rdata  = '0;
      bus_shared = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      bus_gnt     = 1'b0;
      bus_done    = 1'b0;
      bus_rdata   = '0;
      bus_shared  = 1'b0;
      snoop_valid = 1'b0;
      snoop_cmd   = '0;
      snoop_addr  = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      tick;
      reset = 1'b0;
      $display("[TB] reset released");

      checkOutput("rst_ack", cpu_ack, 0);
      checkOutput("rst_bus_req", bus_req, 0);
      checkOutput("rst_snoop_hit", snoop_hit, 0);
      checkOutput("rst_l0_valid", dut.lines[0].valid, 0);

      // Read miss to 0x40, exclusive fill
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      tick;
      serveBus("rdmiss", BUS_RD, 32'h0000_0040, FILL_A, 1'b0, '0);
      checkOutput("rdmiss_ack", cpu_ack, 1);
      checkOutput("rdmiss_rdata", cpu_rdata, 32'h0000_000A);
      checkOutput("rdmiss_state", dut.lines[0].state, EXCLUSIVE);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      checkOutput("rdmiss_single_ack", cpu_ack, 0);
      checkOutput("rdmiss_bus_idle", bus_req, 0);

      // Read hit, one-cycle ack
      applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0);
      tick;
      checkOutput("rdhit_ack", cpu_ack, 1);
      checkOutput("rdhit_rdata", cpu_rdata, 32'h0000_000B);
      checkOutput("rdhit_nobus", bus_req, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      // Write hit on E line
      applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234);
      tick;
      checkOutput("wrhit_ack", cpu_ack, 1);
      checkOutput("wrhit_nobus", bus_req, 0);
      checkOutput("wrhit_state", dut.lines[0].state, MODIFIED);
      checkOutput("wrhit_dirty", dut.lines[0].dirty, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      // Snoop BUS_RD on M line
      snoop(BUS_RD, 32'h0000_0040);
      tick;
      snoop_valid = 1'b0;
      checkOutput("snprd_hit", snoop_hit, 1);
      checkOutput("snprd_flush", snoop_flush, 1);
      checkOutput("snprd_data", snoop_data,
                  {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_1234});
      checkOutput("snprd_state", dut.lines[0].state, SHARED);
      tick;
      checkOutput("snprd_pulse", snoop_hit, 0);

      // Write to S line: upgrade
      applyStimulus(1'b1, 1'b1, 32'h0000_0044, 32'h0000_5555);
      tick;
      serveBus("upg", BUS_UPGR, 32'h0000_0040, '0, 1'b0, '0);
      checkOutput("upg_ack", cpu_ack, 1);
      checkOutput("upg_state", dut.lines[0].state, MODIFIED);
      checkOutput("upg_data", dut.lines[0].data,
                  {32'h0000_000D, 32'h0000_000C, 32'h0000_5555, 32'h0000_1234});
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      // Back to S, then upgrade lost to a competing BusUpgr
      snoop(BUS_RD, 32'h0000_0040);
      tick;
      snoop_valid = 1'b0;
      checkOutput("snprd2_state", dut.lines[0].state, SHARED);
      applyStimulus(1'b1, 1'b1, 32'h0000_0048, 32'h0000_7777);
      tick;
      checkOutput("upglost_cmd0", bus_cmd, BUS_UPGR);
      snoop(BUS_UPGR, 32'h0000_0040);
      tick;
      snoop_valid = 1'b0;
      checkOutput("upglost_snphit", snoop_hit, 1);
      checkOutput("upglost_noflush", snoop_flush, 0);
      checkOutput("upglost_inval", dut.lines[0].valid, 0);
      serveBus("upglost", BUS_RDX, 32'h0000_0040, FILL_B, 1'b0, '0);
      checkOutput("upglost_ack", cpu_ack, 1);
      checkOutput("upglost_state", dut.lines[0].state, MODIFIED);
      checkOutput("upglost_data", dut.lines[0].data,
                  {32'h4444_0003, 32'h0000_7777, 32'h4444_0001, 32'h4444_0000});
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      // Read miss to 0x80 evicting dirty 0x40
      applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h0);
      tick;
      serveBus("evict", BUS_FLUSH, 32'h0000_0040, '0, 1'b0,
               {32'h4444_0003, 32'h0000_7777, 32'h4444_0001, 32'h4444_0000});
      checkOutput("evict_no_early_ack", cpu_ack, 0);
      serveBus("evfill", BUS_RD, 32'h0000_0080, FILL_C, 1'b1, '0);
      checkOutput("evfill_ack", cpu_ack, 1);
      checkOutput("evfill_rdata", cpu_rdata, 32'h8888_0000);
      checkOutput("evfill_state", dut.lines[0].state, SHARED);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      checkOutput("evfill_single_ack", cpu_ack, 0);

      // Reset during FILL_WAIT
      applyStimulus(1'b1, 1'b0, 32'h0000_00C0, 32'h0);
      tick;
      checkOutput("rstfill_cmd", bus_cmd, BUS_RD);
      bus_gnt = 1'b1;
      tick;
      bus_gnt = 1'b0;
      reset   = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      reset = 1'b0;
      checkOutput("rstfill_req", bus_req, 0);
      checkOutput("rstfill_cmd0", bus_cmd, 0);
      checkOutput("rstfill_addr", bus_addr, 0);
      checkOutput("rstfill_ack", cpu_ack, 0);
      for (int i = 0; i < NUM_LINES; i++)
         checkOutput($sformatf("rstfill_l%0d_valid", i), dut.lines[i].valid, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_00C0, 32'h0);
      tick;
      serveBus("postrst", BUS_RD, 32'h0000_00C0, FILL_D, 1'b0, '0);
      checkOutput("postrst_ack", cpu_ack, 1);
      checkOutput("postrst_state", dut.lines[0].state, EXCLUSIVE);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      // Hit-write colliding with a snoop read on the same line
      applyStimulus(1'b1, 1'b1, 32'h0000_00C0, 32'h0000_9999);
      snoop(BUS_RD, 32'h0000_00C0);
      tick;
      snoop_valid = 1'b0;
      checkOutput("race_no_ack", cpu_ack, 0);
      checkOutput("race_snphit", snoop_hit, 1);
      checkOutput("race_snpflush", snoop_flush, 0);
      tick;
      serveBus("race_upg", BUS_UPGR, 32'h0000_00C0, '0, 1'b0, '0);
      checkOutput("race_ack", cpu_ack, 1);
      checkOutput("race_state", dut.lines[0].state, MODIFIED);
      checkOutput("race_word", dut.lines[0].data[31:0], 32'h0000_9999);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
